// File: rtl/instr_emitter_if.sv
// Producer handshake and emitter status bundle for instr_emitter.
// The tri-state data_bus stays a plain port on the emitter itself.
interface instr_emitter_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] opcode;
    logic [2:0] op0;
    logic [2:0] op1;
    logic [2:0] op2;
    logic       dataE;
    logic       notLoad;
    logic [2:0] count;
    logic       busy;

    modport master (
        output in_valid, opcode, op0, op1, op2,
        input  in_ready, dataE, notLoad, count, busy
    );

    modport slave (
        input  in_valid, opcode, op0, op1, op2,
        output in_ready, dataE, notLoad, count, busy
    );
endinterface

// File: rtl/instr_emitter.sv
// Queues packed instruction words and emits each onto a tri-state bus with a one-cycle
// active-low load strobe. Optional SETUP stall input is enabled by EMIT_STALL_EN.
module instr_emitter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
`ifdef EMIT_STALL_EN
    input  logic stall,
`endif
    instr_emitter_if.slave bus_if,
    output wire [15:0] data_bus
);

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, LOAD, HOLD} state_t;

    state_t              state_q;
    state_t              state_nxt_c;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    cnt_nxt_c;
    logic                in_ready_q;
    logic                dataE_q;
    logic                notLoad_q;
    logic                busy_q;
    logic                push_c;
    logic                pop_c;
    logic                stall_c;
    logic [WORD_W-1:0]   word_c;

`ifdef EMIT_STALL_EN
    assign stall_c = stall;
`else
    assign stall_c = 1'b0;
`endif

    assign word_c = {bus_if.opcode, bus_if.op0, bus_if.op1, bus_if.op2};

    // Occupancy bookkeeping; the head word leaves on the HOLD exit edge.
    always_comb begin
        push_c    = bus_if.in_valid && in_ready_q;
        pop_c     = (state_q == HOLD);
        cnt_nxt_c = count_q;
        if (push_c && !pop_c) begin
            cnt_nxt_c = count_q + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            cnt_nxt_c = count_q - CNT_W'(1);
        end
    end

    // HOLD looks only at the words left behind, so a same-edge push waits a cycle in IDLE.
    always_comb begin
        state_nxt_c = state_q;
        case (state_q)
            IDLE:    if (count_q != '0) state_nxt_c = SETUP;
            SETUP:   if (!stall_c) state_nxt_c = LOAD;
            LOAD:    state_nxt_c = HOLD;
            HOLD:    state_nxt_c = (count_q > CNT_W'(1)) ? SETUP : IDLE;
            default: state_nxt_c = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
            dataE_q    <= 1'b0;
            notLoad_q  <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt_c;
            count_q    <= cnt_nxt_c;
            in_ready_q <= (cnt_nxt_c < CNT_W'(DEPTH));
            dataE_q    <= (state_nxt_c != IDLE);
            notLoad_q  <= (state_nxt_c != LOAD);
            busy_q     <= (state_nxt_c != IDLE);
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (!reset && push_c) begin
            mem[wr_ptr_q] <= word_c;
        end
    end

    assign data_bus        = dataE_q ? mem[rd_ptr_q] : {WORD_W{1'bz}};
    assign bus_if.in_ready = in_ready_q;
    assign bus_if.dataE    = dataE_q;
    assign bus_if.notLoad  = notLoad_q;
    assign bus_if.count    = count_q;
    assign bus_if.busy     = busy_q;

endmodule

// File: tb/tb_instr_emitter.sv
// Directed bench for instr_emitter; stall scenario is built only with EMIT_STALL_EN.
module tb_instr_emitter;

    logic        clock;
    logic        reset;
`ifdef EMIT_STALL_EN
    logic        stall;
`endif
    wire  [15:0] data_bus;

    instr_emitter_if ifc ();

    instr_emitter #(.DEPTH(4)) dut (
        .clock    (clock),
        .reset    (reset),
`ifdef EMIT_STALL_EN
        .stall    (stall),
`endif
        .bus_if   (ifc),
        .data_bus (data_bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [15:0] sw [$];
    int          sc [$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One clock; samples 1 time unit after the edge and logs any load strobe.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (ifc.notLoad === 1'b0) begin
            sw.push_back(data_bus);
            sc.push_back(cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] a,
                         input logic [2:0] b, input logic [2:0] c);
        ifc.in_valid = v;
        ifc.opcode   = opc;
        ifc.op0      = a;
        ifc.op1      = b;
        ifc.op2      = c;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 7'h0, 3'h0, 3'h0, 3'h0);
        tick();
        tick();
        if (ifc.dataE !== 1'b0) begin bad++; $display("FAIL reset_dataE got=%b exp=0", ifc.dataE); end
        total++;
        if (ifc.notLoad !== 1'b1) begin bad++; $display("FAIL reset_notLoad got=%b exp=1", ifc.notLoad); end
        total++;
        if (ifc.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ifc.count); end
        total++;
        if (ifc.busy !== 1'b0 || ifc.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_busy_ready got=%b%b exp=01", ifc.busy, ifc.in_ready);
        end
        total++;
        reset = 1'b0;
        tick();
        if (ifc.busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy got=%b exp=0", ifc.busy); end
        total++;
    endtask

    task automatic test_single();
        int k;
        sw.delete(); sc.delete();
        drive(1'b1, 7'b1010111, 3'b101, 3'b110, 3'b011);
        tick();
        k = cyc;
        drive(1'b0, 7'h0, 3'h0, 3'h0, 3'h0);
        if (ifc.count !== 3'd1 || ifc.dataE !== 1'b0) begin
            bad++; $display("FAIL single_k count=%0d dataE=%b exp=1/0", ifc.count, ifc.dataE);
        end
        total++;
        tick();
        if (ifc.dataE !== 1'b1 || ifc.notLoad !== 1'b1 || data_bus !== 16'hAF73) begin
            bad++; $display("FAIL single_setup dataE=%b notLoad=%b bus=%h exp=1/1/af73", ifc.dataE, ifc.notLoad, data_bus);
        end
        total++;
        tick();
        if (ifc.notLoad !== 1'b0 || data_bus !== 16'hAF73) begin
            bad++; $display("FAIL single_load notLoad=%b bus=%h exp=0/af73", ifc.notLoad, data_bus);
        end
        total++;
        tick();
        if (ifc.dataE !== 1'b1 || ifc.notLoad !== 1'b1 || data_bus !== 16'hAF73) begin
            bad++; $display("FAIL single_hold dataE=%b notLoad=%b bus=%h exp=1/1/af73", ifc.dataE, ifc.notLoad, data_bus);
        end
        total++;
        tick();
        if (ifc.dataE !== 1'b0 || ifc.busy !== 1'b0 || ifc.count !== 3'd0) begin
            bad++; $display("FAIL single_done dataE=%b busy=%b count=%0d exp=0/0/0", ifc.dataE, ifc.busy, ifc.count);
        end
        total++;
        if (sc.size() != 1 || sc[0] != k + 2) begin
            bad++; $display("FAIL single_strobe n=%0d first=%0d exp=1 at %0d", sc.size(), (sc.size() > 0) ? sc[0] : -1, k + 2);
        end
        total++;
    endtask

    task automatic test_hold_push();
        drive(1'b1, 7'h12, 3'd1, 3'd2, 3'd3);
        tick();
        drive(1'b0, 7'h0, 3'h0, 3'h0, 3'h0);
        tick(); tick(); tick();
        if (ifc.notLoad !== 1'b1 || ifc.dataE !== 1'b1 || ifc.count !== 3'd1 || data_bus !== 16'h2453) begin
            bad++; $display("FAIL hold_state notLoad=%b dataE=%b count=%0d bus=%h exp=1/1/1/2453",
                            ifc.notLoad, ifc.dataE, ifc.count, data_bus);
        end
        total++;
        drive(1'b1, 7'h7E, 3'd6, 3'd5, 3'd4);
        tick();
        drive(1'b0, 7'h0, 3'h0, 3'h0, 3'h0);
        if (ifc.dataE !== 1'b0 || ifc.busy !== 1'b0 || ifc.count !== 3'd1) begin
            bad++; $display("FAIL hold_push_idle dataE=%b busy=%b count=%0d exp=0/0/1", ifc.dataE, ifc.busy, ifc.count);
        end
        total++;
        tick();
        if (ifc.dataE !== 1'b1 || data_bus !== 16'hFDAC) begin
            bad++; $display("FAIL hold_push_setup dataE=%b bus=%h exp=1/fdac", ifc.dataE, data_bus);
        end
        total++;
        tick(); tick(); tick();
        if (ifc.count !== 3'd0 || ifc.busy !== 1'b0) begin
            bad++; $display("FAIL hold_push_drain count=%0d busy=%b exp=0/0", ifc.count, ifc.busy);
        end
        total++;
    endtask

    task automatic test_back_to_back();
        logic [6:0]  opc [5] = '{7'h12, 7'h7F, 7'h40, 7'h05, 7'h33};
        logic [2:0]  a   [5] = '{3'd1, 3'd7, 3'd4, 3'd2, 3'd3};
        logic [2:0]  b   [5] = '{3'd2, 3'd7, 3'd0, 3'd5, 3'd3};
        logic [2:0]  c   [5] = '{3'd3, 3'd7, 3'd1, 3'd6, 3'd3};
        logic [15:0] exp [4] = '{16'h2453, 16'hFFFF, 16'h8101, 16'h0AAE};
        int k0;
        sw.delete(); sc.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, opc[i], a[i], b[i], c[i]);
            tick();
            if (i == 0) k0 = cyc;
        end
        if (ifc.count !== 3'd4 || ifc.in_ready !== 1'b0) begin
            bad++; $display("FAIL full count=%0d in_ready=%b exp=4/0", ifc.count, ifc.in_ready);
        end
        total++;
        drive(1'b1, opc[4], a[4], b[4], c[4]);
        tick();
        drive(1'b0, 7'h0, 3'h0, 3'h0, 3'h0);
        if (ifc.count !== 3'd3 || ifc.in_ready !== 1'b1) begin
            bad++; $display("FAIL full_refuse count=%0d in_ready=%b exp=3/1", ifc.count, ifc.in_ready);
        end
        total++;
        for (int i = 0; i < 20; i++) tick();
        if (sw.size() != 4) begin
            bad++; $display("FAIL b2b_strobes got=%0d exp=4", sw.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sw[i] !== exp[i] || sc[i] != k0 + 2 + 3 * i) begin
                    bad++; $display("FAIL b2b_word%0d got=%h@%0d exp=%h@%0d", i, sw[i], sc[i], exp[i], k0 + 2 + 3 * i);
                end
                total++;
            end
        end
        total++;
        if (ifc.count !== 3'd0 || ifc.busy !== 1'b0) begin
            bad++; $display("FAIL b2b_drain count=%0d busy=%b exp=0/0", ifc.count, ifc.busy);
        end
        total++;
    endtask

    task automatic test_wrap();
        logic [6:0]  opc [6] = '{7'h01, 7'h02, 7'h7E, 7'h2A, 7'h15, 7'h60};
        logic [2:0]  a   [6] = '{3'd0, 3'd1, 3'd6, 3'd2, 3'd5, 3'd7};
        logic [2:0]  b   [6] = '{3'd0, 3'd1, 3'd5, 3'd4, 3'd3, 3'd0};
        logic [2:0]  c   [6] = '{3'd1, 3'd1, 3'd4, 3'd6, 3'd1, 3'd7};
        logic [15:0] exp [6] = '{16'h0201, 16'h0449, 16'hFDAC, 16'h54A6, 16'h2B59, 16'hC1C7};
        sw.delete(); sc.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, opc[i], a[i], b[i], c[i]);
            tick();
            drive(1'b0, 7'h0, 3'h0, 3'h0, 3'h0);
            tick();
        end
        for (int i = 0; i < 30; i++) tick();
        if (sw.size() != 6) begin
            bad++; $display("FAIL wrap_strobes got=%0d exp=6", sw.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (sw[i] !== exp[i]) begin
                    bad++; $display("FAIL wrap_word%0d got=%h exp=%h", i, sw[i], exp[i]);
                end
                total++;
            end
        end
        total++;
    endtask

    task automatic test_reset_in_load();
        int n;
        drive(1'b1, 7'h7F, 3'd7, 3'd7, 3'd7); tick();
        drive(1'b1, 7'h40, 3'd4, 3'd0, 3'd1); tick();
        drive(1'b1, 7'h05, 3'd2, 3'd5, 3'd6); tick();
        if (ifc.notLoad !== 1'b0 || ifc.count !== 3'd3) begin
            bad++; $display("FAIL rst_pre notLoad=%b count=%0d exp=0/3", ifc.notLoad, ifc.count);
        end
        total++;
        reset = 1'b1;
        drive(1'b1, 7'h33, 3'd3, 3'd3, 3'd3);
        tick();
        reset = 1'b0;
        drive(1'b0, 7'h0, 3'h0, 3'h0, 3'h0);
        if (ifc.dataE !== 1'b0 || ifc.notLoad !== 1'b1 || ifc.count !== 3'd0 || ifc.busy !== 1'b0) begin
            bad++; $display("FAIL rst_load dataE=%b notLoad=%b count=%0d busy=%b exp=0/1/0/0",
                            ifc.dataE, ifc.notLoad, ifc.count, ifc.busy);
        end
        total++;
        n = sw.size();
        for (int i = 0; i < 10; i++) tick();
        if (sw.size() != n || ifc.dataE !== 1'b0) begin
            bad++; $display("FAIL rst_no_strobe extra=%0d dataE=%b exp=0/0", sw.size() - n, ifc.dataE);
        end
        total++;
    endtask

`ifdef EMIT_STALL_EN
    task automatic test_stall();
        drive(1'b1, 7'h2A, 3'd2, 3'd4, 3'd6);
        tick();
        drive(1'b0, 7'h0, 3'h0, 3'h0, 3'h0);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ifc.notLoad !== 1'b1 || ifc.dataE !== 1'b1 || data_bus !== 16'h54A6) begin
                bad++; $display("FAIL stall_hold%0d notLoad=%b dataE=%b bus=%h exp=1/1/54a6",
                                i, ifc.notLoad, ifc.dataE, data_bus);
            end
            total++;
        end
        stall = 1'b0;
        tick();
        if (ifc.notLoad !== 1'b0 || data_bus !== 16'h54A6) begin
            bad++; $display("FAIL stall_release notLoad=%b bus=%h exp=0/54a6", ifc.notLoad, data_bus);
        end
        total++;
        tick(); tick();
        if (ifc.busy !== 1'b0) begin bad++; $display("FAIL stall_drain busy=%b exp=0", ifc.busy); end
        total++;
    endtask
`endif

    initial begin
        reset = 1'b1;
`ifdef EMIT_STALL_EN
        stall = 1'b0;
`endif
        drive(1'b0, 7'h0, 3'h0, 3'h0, 3'h0);
        test_reset();
        test_single();
        test_hold_push();
        test_back_to_back();
        test_wrap();
        test_reset_in_load();
`ifdef EMIT_STALL_EN
        test_stall();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_emitter.md
INSTR_EMITTER -- requirements
Module: instr_emitter

Interface
REQ-001 SHALL have ports: clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  input  1  producer offers one instruction this cycle.
REQ-004 SHALL have ports: in_ready  output  1  queue can accept an instruction this cycle.
REQ-005 SHALL have ports: opcode  input  7  instruction opcode field.
REQ-006 SHALL have ports: op0, op1, op2  input  3 each  operand fields.
REQ-007 SHALL have ports: data_bus  output (tri-state)  16  instruction word, high-impedance when not driven.
REQ-008 SHALL have ports: dataE  output  1  bus-drive enable, high while data_bus is driven.
REQ-009 SHALL have ports: notLoad  output  1  active-low load strobe to the instruction register.
REQ-010 SHALL have ports: count  output  3  queued instructions, 0..4.
REQ-011 SHALL have ports: busy  output  1  FSM not in IDLE.
REQ-012 SHALL have port stall (input, 1, hold before load strobe), present only under EMIT_STALL_EN.
REQ-013 SHALL have parameter DEPTH, default 4, queue entries (fixed at 4 in this revision).

Function
REQ-014 SHALL pack each accepted instruction as word = {opcode, op0, op1, op2}: bits 15:9, 8:6, 5:3, 2:0.
REQ-015 SHALL accept an instruction on a rising edge iff in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready = (count < 4), computed from the registered count only; a pop in the same cycle does not raise in_ready.
REQ-017 SHALL store words in a 4-entry FIFO; 2-bit read/write pointers wrap 3->0.
REQ-018 SHALL use FSM states IDLE, SETUP, LOAD, HOLD.
REQ-019 SHALL transition IDLE->SETUP when count != 0, else remain in IDLE.
REQ-020 SHALL transition SETUP->LOAD unconditionally when the stall feature is absent.
REQ-021 SHALL transition LOAD->HOLD unconditionally.
REQ-022 SHALL pop the head word at the HOLD exit edge, then go to SETUP if count after the pop is nonzero, else to IDLE.
REQ-023 SHALL set outputs per state: IDLE: dataE=0, notLoad=1, bus Z; SETUP and HOLD: dataE=1, notLoad=1, bus = head word; LOAD: dataE=1, notLoad=0, bus = head word.
REQ-024 SHALL hold notLoad low for exactly one clock per word, with data stable one cycle before and one cycle after it.
REQ-025 SHALL meet latency: push at edge k -> SETUP after edge k+1, LOAD after edge k+2, HOLD after edge k+3.
REQ-026 SHALL sustain back-to-back throughput of 1 word per 3 cycles.
REQ-027 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-028 SHALL let a push into an empty queue during HOLD of the last word leave the FSM in IDLE for one cycle before SETUP.
REQ-029 SHALL leave queue and outputs unchanged when in_valid=1 while full; the offered instruction is not accepted.

Reset
REQ-030 SHALL, when reset=1 at a rising edge: state=IDLE, pointers=0, count=0, dataE=0, notLoad=1, data_bus=Z, busy=0, in_ready=1.
REQ-031 SHALL, on reset in any state, abort the in-flight word with no further notLoad pulse and discard all queued words.
REQ-032 SHALL give reset priority over a simultaneous push; the push is discarded.

Configuration
REQ-033 SHALL, with EMIT_STALL_EN defined, add the stall port; SETUP with stall=1 remains in SETUP (dataE=1, notLoad=1); SETUP with stall=0 goes to LOAD; stall is ignored in other states.
REQ-034 SHALL, without EMIT_STALL_EN, have no stall port; behaviour equals stall tied to 0.

Verification
REQ-035 SHALL cover single push of opcode=7'b1010111, op0=3'b101, op1=3'b110, op2=3'b011 -> data_bus=16'hAF73 with notLoad low exactly one cycle after edge k+2 and dataE high for 3 cycles.
REQ-036 SHALL cover four consecutive pushes -> count=4, in_ready=0, a fifth offer rejected; four strobes spaced 3 cycles apart in push order.
REQ-037 SHALL cover push while full during the HOLD pop -> push refused; count goes 4->3.
REQ-038 SHALL cover pointer wrap: 6 pushes interleaved with emission -> words emitted in order with no loss or duplication.
REQ-039 SHALL cover reset asserted in LOAD with count=3 -> next cycle dataE=0, notLoad=1, count=0, and no further strobes.
REQ-040 SHALL cover, with EMIT_STALL_EN, stall=1 for 5 cycles in SETUP -> notLoad stays 1 and the bus holds the word; LOAD follows 1 cycle after stall falls.
